// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: parity encodings, FSM states and frame length.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Bit periods per frame: start + data + optional parity + stop bits.
  function automatic int frame_len(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: frames a byte on tx one bit per clk_en tick.
// A one-deep pending slot lets a byte submitted mid-frame follow with no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 busy
);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] pend;
  logic                 pend_full;
  logic                 par_bit;
  logic [2:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 frame_end;

  function automatic logic calc_par(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY == PAR_ODD);
  endfunction

  assign frame_end = (state == ST_STOP) && clk_en && (stop_cnt == 1'(STOP_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      shreg     <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      par_bit   <= 1'b0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
    end else begin
      // On the frame-end tick a new request is taken directly by the FSM below.
      if (tx_start && (state != ST_IDLE) && !pend_full && !frame_end) begin
        pend      <= tx_data;
        pend_full <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (tx_start) begin
            shreg   <= tx_data;
            par_bit <= calc_par(tx_data);
            busy    <= 1'b1;
            state   <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (clk_en) begin
            tx    <= 1'b0;
            state <= ST_START;
          end
        end

        ST_START: begin
          if (clk_en) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (clk_en) begin
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
              if (PARITY != PAR_NONE) begin
                tx    <= par_bit;
                state <= ST_PARITY;
              end else begin
                tx       <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= ST_STOP;
              end
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

        ST_PARITY: begin
          if (clk_en) begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (frame_end) begin
            if (pend_full) begin
              shreg     <= pend;
              par_bit   <= calc_par(pend);
              pend_full <= 1'b0;
              tx        <= 1'b0;
              state     <= ST_START;
            end else if (tx_start) begin
              // Request on the closing tick: its start bit waits for the next tick.
              shreg   <= tx_data;
              par_bit <= calc_par(tx_data);
              state   <= ST_WAIT;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else if (clk_en) begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: five instances cover default, even/odd parity,
// two stop bits and clk_en tied high; a per-instance monitor decodes frames on ticks.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int N = 5;

  typedef struct {
    logic [11:0] bits;
    bit          b2b;
  } exp_t;

  // Hand-computed frames, bit i = i-th bit on the line (start in bit 0).
  localparam logic [11:0] F55   = 12'b00_1_01010101_0;
  localparam logic [11:0] FA3   = 12'b00_1_10100011_0;
  localparam logic [11:0] FA3E  = 12'b0_1_0_10100011_0;
  localparam logic [11:0] FA3O  = 12'b0_1_1_10100011_0;
  localparam logic [11:0] FA3S2 = 12'b0_1_1_10100011_0;
  localparam logic [11:0] F81   = 12'b00_1_10000001_0;
  localparam logic [11:0] F3C   = 12'b00_1_00111100_0;
  localparam logic [11:0] F0F   = 12'b00_1_00001111_0;

  logic         clk = 1'b0;
  logic [N-1:0] rst;
  logic [N-1:0] en = '0;
  logic [N-1:0] start;
  logic [N-1:0] en_d;
  logic [N-1:0] rst_d;
  logic [N-1:0] tx;
  logic [N-1:0] busy;
  logic [7:0]   data [N];
  exp_t         exp_q [N][$];
  int           checks = 0;
  int           errors = 0;
  int           tick_cnt = 0;

  always #10 clk = ~clk;

  always @(negedge clk) begin
    tick_cnt = (tick_cnt + 1) % 16;
    for (int i = 0; i < N - 1; i++) en[i] = (tick_cnt == 0);
    en[N-1] = 1'b1;
  end

  always @(posedge clk) begin
    en_d  <= en;
    rst_d <= rst;
  end

  for (genvar G = 0; G < N; G++) begin : g_inst
    localparam int PAR = (G == 1) ? PAR_EVEN : (G == 2) ? PAR_ODD : PAR_NONE;
    localparam int STP = (G == 3) ? 2 : 1;
    localparam int LEN = frame_len(8, PAR, STP);

    uart_tx #(.DATA_BITS(8), .PARITY(PAR), .STOP_BITS(STP)) dut (
      .clk      (clk),
      .rst_n    (rst[G]),
      .clk_en   (en[G]),
      .tx_start (start[G]),
      .tx_data  (data[G]),
      .tx       (tx[G]),
      .busy     (busy[G])
    );

    logic [11:0] cur;
    int          nb;
    int          idle;
    int          gap;
    bit          in_frame;
    bit          glitch;
    logic        prev_tx;
    exp_t        e;

    always @(negedge clk) begin
      if (rst_d[G] !== 1'b1) begin
        in_frame = 1'b0;
        nb       = 0;
        idle     = 0;
        glitch   = 1'b0;
        prev_tx  = tx[G];
      end else begin
        if (en_d[G] !== 1'b1 && tx[G] !== prev_tx) glitch = 1'b1;
        prev_tx = tx[G];
        if (en_d[G] === 1'b1) begin
          if (!in_frame) begin
            if (tx[G] === 1'b0) begin
              in_frame = 1'b1;
              cur      = '0;
              nb       = 1;
              gap      = idle;
            end else begin
              idle++;
            end
          end else begin
            cur[nb] = tx[G];
            nb++;
            if (nb == LEN) begin
              in_frame = 1'b0;
              idle     = 0;
              checks++;
              if (exp_q[G].size() == 0) begin
                errors++;
                $display("FAIL frame_unexpected inst %0d: got bits %b, want no frame", G, cur);
              end else begin
                e = exp_q[G].pop_front();
                if (cur[LEN-1:0] !== e.bits[LEN-1:0]) begin
                  errors++;
                  $display("FAIL frame_bits inst %0d: got %b want %b", G, cur[LEN-1:0], e.bits[LEN-1:0]);
                end
                checks++;
                if (glitch) begin
                  errors++;
                  $display("FAIL tx_stable inst %0d: got change off tick, want changes only on clk_en", G);
                end
                glitch = 1'b0;
                if (e.b2b) begin
                  checks++;
                  if (gap != 0) begin
                    errors++;
                    $display("FAIL b2b_gap inst %0d: got %0d idle ticks want 0", G, gap);
                  end
                end
              end
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int g, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst %0d: got %b want %b", name, g, got, want);
    end
  endtask

  task automatic push(input int g, input logic [11:0] b, input bit b2b);
    exp_t x;
    x.bits = b;
    x.b2b  = b2b;
    exp_q[g].push_back(x);
  endtask

  task automatic pulse(input int g, input logic [7:0] d, input bit chk_busy);
    @(negedge clk);
    data[g]  = d;
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    data[g]  = ~d;  // mid-frame data change must not matter
    if (chk_busy) chk("busy_rise", g, busy[g], 1'b1);
  endtask

  task automatic run_ticks(input int g, input int n, output int lo);
    lo = 0;
    for (int k = 0; k < n;) begin
      @(negedge clk);
      if (busy[g] !== 1'b1) lo++;
      if (en_d[g] === 1'b1) k++;
    end
  endtask

  task automatic wait_idle(input int g);
    bit done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      if (busy[g] === 1'b0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_idle inst %0d: got busy still high after 3000 clk, want low", g);
    end
  endtask

  initial begin
    int lo;
    int total;
    rst   = '0;
    start = '0;
    for (int i = 0; i < N; i++) data[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = '1;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      chk("reset_tx", g, tx[g], 1'b1);
      chk("reset_busy", g, busy[g], 1'b0);
    end
    repeat (1000) @(negedge clk);
    chk("idle_tx", 0, tx[0], 1'b1);
    chk("idle_busy", 0, busy[0], 1'b0);

    // Single frame 0x55 with tick-exact start and busy timing.
    push(0, F55, 1'b0);
    pulse(0, 8'h55, 1'b1);
    run_ticks(0, 1, lo);
    chk("start_bit", 0, tx[0], 1'b0);
    total = lo;
    run_ticks(0, 9, lo);
    total += lo;
    chk("stop_bit", 0, tx[0], 1'b1);
    chk("busy_in_frame", 0, (total == 0), 1'b1);
    run_ticks(0, 1, lo);
    chk("busy_fall", 0, busy[0], 1'b0);
    repeat (40) @(negedge clk);

    // Back-to-back: 0xA3 during the stop bit, 0xFF dropped; 0x81 during 0xA3, 0x7E dropped.
    push(0, F55, 1'b0);
    push(0, FA3, 1'b1);
    push(0, F81, 1'b1);
    pulse(0, 8'h55, 1'b1);
    run_ticks(0, 10, lo);
    total = lo;
    pulse(0, 8'hA3, 1'b0);
    pulse(0, 8'hFF, 1'b0);
    run_ticks(0, 3, lo);
    total += lo;
    pulse(0, 8'h81, 1'b0);
    pulse(0, 8'h7E, 1'b0);
    run_ticks(0, 17, lo);
    total += lo;
    chk("busy_b2b", 0, (total == 0), 1'b1);
    run_ticks(0, 1, lo);
    chk("busy_fall_b2b", 0, busy[0], 1'b0);
    repeat (40) @(negedge clk);

    // Parity and stop-bit variants.
    push(1, FA3E, 1'b0);
    push(2, FA3O, 1'b0);
    push(3, FA3S2, 1'b0);
    for (int g = 1; g <= 3; g++) begin
      pulse(g, 8'hA3, 1'b1);
      wait_idle(g);
    end

    // Reset during data bit 3, then a clean frame.
    pulse(0, 8'hA3, 1'b1);
    run_ticks(0, 5, lo);
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    @(negedge clk);
    chk("midreset_tx", 0, tx[0], 1'b1);
    chk("midreset_busy", 0, busy[0], 1'b0);
    rst[0] = 1'b1;
    repeat (20) @(negedge clk);
    push(0, F3C, 1'b0);
    pulse(0, 8'h3C, 1'b1);
    wait_idle(0);

    // clk_en tied high: one bit per clk.
    push(4, F0F, 1'b0);
    pulse(4, 8'h0F, 1'b1);
    wait_idle(4);

    repeat (50) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      checks++;
      if (exp_q[g].size() != 0) begin
        errors++;
        $display("FAIL frames_missing inst %0d: got %0d frames outstanding want 0", g, exp_q[g].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
